nibble_serial_sub: RTL and testbench
====================================

Name: nibble_serial_sub

Overview:
- Multi-cycle subtractor: computes A - B - b_in one 4-bit slice per clock, LSB nibble first.
- Each slice uses 4-bit borrow-lookahead logic, the subtraction counterpart of the team's 4-bit carry-lookahead adder.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Serves as the subtract/compare path alongside the CLA adder.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4; slice count N = WIDTH/4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- b_in  input  1  borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- diff  output  WIDTH  A - B - b_in, modulo 2^WIDTH
- b_out  output  1  final borrow; 1 when A < B + b_in (unsigned)
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset: rst_n=0 sampled at a rising clk edge. That edge forces:
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - diff=0, b_out=0, slice index=0
  - all operand and borrow registers cleared
- Reset takes priority over every other event, including mid-RUN and DONE. Any in-flight operation is discarded and no result is produced.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid & in_ready: latch a, b, b_in into operand registers. Set borrow register = b_in, slice index = 0. Go to RUN.
- State RUN:
  - in_ready=0.
  - Each edge processes slice k = index, bits [4k+3:4k]. Per bit i:
    - d_i = a_i ^ b_i ^ c_i
    - g_i = ~a_i & b_i
    - p_i = ~(a_i ^ b_i)
    - c_(i+1) = g_i | (p_i & c_i)
  - Slice borrows are computed in lookahead form from g, p and the slice borrow-in, not rippled.
  - Slice result is written into diff[4k+3:4k]; the borrow register takes c_4.
  - Index increments. After slice N-1, go to DONE and set b_out = final borrow.
  - diff bits of unprocessed slices hold 0 while running.
- State DONE:
  - out_valid=1; diff and b_out are stable and unchanged while out_ready=0.
  - On an edge with out_valid & out_ready: out_valid→0, go to IDLE, in_ready=1 from the next cycle.
  - diff and b_out keep their last values in IDLE until the next accept, which clears diff to 0.
- Latency: accept edge at cycle t; out_valid high from the edge at t+N. Default WIDTH gives 4 cycles.
- Throughput: one operation per N+2 cycles minimum (accept, N slices, handshake out). in_ready is not combinationally tied to out_ready; there is no overlap.
- in_valid while busy is ignored; the source must hold its data until accepted.
- Wrap-around: the result is modulo 2^WIDTH. Example: 0 - 1 gives diff = all ones, b_out=1.
- Operands are captured at accept; later changes on a, b or b_in have no effect on the operation in flight.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_OVF_EN
- Defined:
  - Extra output port ovf (1 bit) holds signed two's-complement overflow.
  - ovf = (a[MSB] ^ b[MSB]) & (diff[MSB] ^ a[MSB]), using the latched operands.
  - ovf is valid with out_valid, holds in DONE, resets to 0, and clears on accept.
- Not defined:
  - Port ovf does not exist and no overflow logic is synthesized.
  - All other behaviour is identical.

Test Plan:
- Reset then basic subtract: rst_n low 2 cycles; a=0x1234, b=0x0034, b_in=0, out_ready=1.
  - out_valid rises exactly 4 cycles after accept; diff=0x1200, b_out=0.
- Underflow: a=0x0000, b=0x0001, b_in=0 → diff=0xFFFF, b_out=1. With the macro: ovf=0.
- Borrow-in plus cross-slice borrow chain:
  - a=0x1000, b=0x0000, b_in=1 → diff=0x0FFF, b_out=0.
  - a=0x0005, b=0x0003, b_in=1 → diff=0x0001.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with a=0xFFFF, b=0x00FF.
  - diff=0xFF00 and out_valid stay stable; in_ready stays 0; a new in_valid pulse is not accepted.
  - Raise out_ready: one handshake, then in_ready=1.
- Reset mid-operation: accept a=0xABCD, b=0x1111, then assert rst_n=0 at the second RUN cycle.
  - Next cycle: state IDLE, out_valid=0, diff=0, in_ready=1.
  - No result ever appears for the aborted operation.
- Signed overflow (macro defined): a=0x8000, b=0x0001 → diff=0x7FFF, b_out=0, ovf=1. a=0x7FFF, b=0xFFFF → diff=0x8000, ovf=1, b_out=1.

Source files
------------

// File: rtl/nibble_serial_sub_if.sv
// Operand/result handshake bundle for nibble_serial_sub.
// NIBBLE_SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface nibble_serial_sub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             busy;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, b_in, out_ready,
    input  in_ready, out_valid, diff, b_out, busy, ovf
  );

  modport slave (
    input  in_valid, a, b, b_in, out_ready,
    output in_ready, out_valid, diff, b_out, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, b_in, out_ready,
    input  in_ready, out_valid, diff, b_out, busy
  );

  modport slave (
    input  in_valid, a, b, b_in, out_ready,
    output in_ready, out_valid, diff, b_out, busy
  );
`endif
endinterface

// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor: A - B - b_in, one 4-bit borrow-lookahead slice per clock.
// Optional signed overflow output under NIBBLE_SERIAL_SUB_OVF_EN.
module nibble_serial_sub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  nibble_serial_sub_if.slave bus
);

  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OFS_W = IDX_W + 2;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_sub: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [WIDTH-1:0] r_a,         w_a_nxt;
  logic [WIDTH-1:0] r_b,         w_b_nxt;
  logic [WIDTH-1:0] r_diff,      w_diff_nxt;
  logic             r_borrow,    w_borrow_nxt;
  logic [IDX_W-1:0] r_idx,       w_idx_nxt;
  logic             r_in_ready,  w_in_ready_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_busy,      w_busy_nxt;
  logic             r_b_out,     w_b_out_nxt;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
  logic             r_ovf,       w_ovf_nxt;
`endif

  // Current slice operands
  logic [OFS_W-1:0] w_ofs;
  logic [3:0]       w_sa, w_sb, w_g, w_p, w_sd;
  logic [4:0]       w_c;
  logic             w_last;

  assign w_ofs  = {r_idx, 2'b00};
  assign w_sa   = r_a[w_ofs +: 4];
  assign w_sb   = r_b[w_ofs +: 4];
  assign w_last = (r_idx == IDX_W'(N - 1));

  // Borrow generate / propagate and lookahead borrows for one nibble
  always_comb begin
    w_g    = ~w_sa & w_sb;
    w_p    = ~(w_sa ^ w_sb);
    w_c[0] = r_borrow;
    w_c[1] = w_g[0] | (w_p[0] & r_borrow);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_borrow);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);
    w_sd   = w_sa ^ w_sb ^ w_c[3:0];
  end

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_diff_nxt   = r_diff;
    w_borrow_nxt = r_borrow;
    w_idx_nxt    = r_idx;
    w_b_out_nxt  = r_b_out;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
    w_ovf_nxt    = r_ovf;
`endif

    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_a_nxt      = bus.a;
          w_b_nxt      = bus.b;
          w_borrow_nxt = bus.b_in;
          w_idx_nxt    = '0;
          w_diff_nxt   = '0;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
          w_ovf_nxt    = 1'b0;
`endif
          w_state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        w_diff_nxt[w_ofs +: 4] = w_sd;
        w_borrow_nxt           = w_c[4];
        if (w_last) begin
          w_idx_nxt   = '0;
          w_b_out_nxt = w_c[4];
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
          w_ovf_nxt   = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_sd[3] ^ r_a[WIDTH-1]);
`endif
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (r_out_valid && bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_b_out     <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_diff      <= w_diff_nxt;
      r_borrow    <= w_borrow_nxt;
      r_idx       <= w_idx_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_b_out     <= w_b_out_nxt;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
      r_ovf       <= w_ovf_nxt;
`endif
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.b_out     = r_b_out;
  assign bus.busy      = r_busy;
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
  assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed-vector bench for nibble_serial_sub (WIDTH=16), plus backpressure and mid-run reset sequences.
module tb_nibble_serial_sub;

  localparam int unsigned WIDTH = 16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  nibble_serial_sub_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Wait for in_ready, present operands for one edge, then scramble the inputs
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.b_in     = bin;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 16'h5A5A;
    bus.b        = 16'hA5A5;
    bus.b_in     = ~bin;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
    chk("diff_cleared_on_accept", 32'(bus.diff), 32'd0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t tv[12];
  int   lat;
  logic seen;

  initial begin
    tv[0]  = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    tv[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tv[2]  = '{16'h1000, 16'h0000, 1'b1, 16'h0FFF, 1'b0, 1'b0};
    tv[3]  = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
    tv[4]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tv[5]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    tv[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tv[7]  = '{16'hABCD, 16'h1111, 1'b0, 16'h9ABC, 1'b0, 1'b0};
    tv[8]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tv[9]  = '{16'h00F0, 16'h0010, 1'b1, 16'h00DF, 1'b0, 1'b0};
    tv[10] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    tv[11] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.b_in      = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_b_out", 32'(bus.b_out), 32'd0);
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      start_op(tv[i].a, tv[i].b, tv[i].bin);
      wait_valid(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d_diff", i), 32'(bus.diff), 32'(tv[i].d));
      chk($sformatf("v%0d_b_out", i), 32'(bus.b_out), 32'(tv[i].bo));
`ifdef NIBBLE_SERIAL_SUB_OVF_EN
      chk($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(tv[i].ovf));
`endif
      @(negedge clk);
      chk($sformatf("v%0d_out_valid_drop", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("v%0d_in_ready_back", i), 32'(bus.in_ready), 32'd1);
      chk($sformatf("v%0d_diff_held", i), 32'(bus.diff), 32'(tv[i].d));
    end

    // Backpressure: result held while the sink stalls, new operands refused
    bus.out_ready = 1'b0;
    start_op(16'hFFFF, 16'h00FF, 1'b0);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid_hold", 32'(bus.out_valid), 32'd1);
      chk("bp_diff_hold", 32'(bus.diff), 32'h0000FF00);
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b1;
      bus.a        = 16'h1111;
      bus.b        = 16'h0000;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("bp_out_valid_final", 32'(bus.out_valid), 32'd1);
    chk("bp_diff_final", 32'(bus.diff), 32'h0000FF00);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    chk("bp_diff_after", 32'(bus.diff), 32'h0000FF00);
    chk("bp_b_out_after", 32'(bus.b_out), 32'd0);
    @(negedge clk);
    chk("bp_no_stale_accept", 32'(bus.busy), 32'd0);

    // Reset during the second RUN cycle aborts the operation
    start_op(16'hABCD, 16'h1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_diff", 32'(bus.diff), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) seen = 1'b1;
    end
    chk("mrst_no_result", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
